// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button debouncer.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } btn_state_t;

    // Width needed to hold the largest of the three cycle counts.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// Single button channel: 2-flop synchroniser, debounce FSM, press/release pulses.
// Auto-repeat timer present only when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 270000,
    parameter int unsigned REPEAT_DELAY    = 13500000,
    parameter int unsigned REPEAT_PERIOD   = 2700000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CW'(1);
    endfunction

    logic [1:0]    sync_q;
    logic          s;
    btn_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_d, press_d, release_d;

    // Raw pin is synchronised as-is so the reset value 1 means released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], btn_n};
    end

    assign s = ~sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            btn_level   <= level_d;
            btn_press   <= press_d;
            btn_release <= release_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = btn_level;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= DB_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            HELD: begin
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q >= DB_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CW-1:0] RPT_FIRST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RPT_NEXT  = CW'(REPEAT_PERIOD - 1);

    logic [CW-1:0] rcnt_q, rcnt_d;
    logic          first_q, first_d;
    logic          repeat_q, repeat_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt_q   <= '0;
            first_q  <= 1'b0;
            repeat_q <= 1'b0;
        end else begin
            rcnt_q   <= rcnt_d;
            first_q  <= first_d;
            repeat_q <= repeat_d;
        end
    end

    // Timer restarts on the press pulse and runs through RELEASE_WAIT bounces.
    always_comb begin
        rcnt_d   = rcnt_q;
        first_d  = first_q;
        repeat_d = 1'b0;
        if (press_d) begin
            rcnt_d  = '0;
            first_d = 1'b1;
        end else if (release_d || !btn_level) begin
            rcnt_d  = '0;
            first_d = 1'b0;
        end else if (rcnt_q >= (first_q ? RPT_FIRST : RPT_NEXT)) begin
            rcnt_d   = '0;
            first_d  = 1'b0;
            repeat_d = 1'b1;
        end else begin
            rcnt_d = sat_inc(rcnt_q);
        end
    end

    assign btn_repeat = repeat_q;
`else
    assign btn_repeat = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel push-button conditioner; one btn_debounce_ch per button.
// Define BTN_AUTOREPEAT_EN to enable auto-repeat pulses on btn_repeat.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN           = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 270000,
    parameter int unsigned REPEAT_DELAY    = 13500000,
    parameter int unsigned REPEAT_PERIOD   = 2700000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_n,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .btn_n       (btn_n[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_repeat  (btn_repeat[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce: stimulus queues expected pulses, a monitor matches them.
module tb_btn_debounce;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] btn_n;
    logic [1:0] btn_level, btn_press, btn_release, btn_repeat;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    typedef struct {
        int kind;   // 0 press, 1 release, 2 repeat
        int ch;
        int at;
    } ev_t;

    ev_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    btn_debounce #(
        .N_BTN           (2),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_n       (btn_n),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_repeat  (btn_repeat)
    );

    function automatic string kname(input int k);
        case (k)
            0:       return "press";
            1:       return "release";
            default: return "repeat";
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_ev(input int kind, input int ch, input int at);
        ev_t e;
        e.kind = kind;
        e.ch   = ch;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic check_level(input string name, input logic [1:0] want);
        checks++;
        if (btn_level !== want) begin
            failures++;
            $display("FAIL %s: btn_level=%b expected %b (cycle %0d)", name, btn_level, want, cyc);
        end
    endtask

    task automatic check_pulses_zero(input string name);
        checks++;
        if ({btn_press, btn_release, btn_repeat} !== 6'b0) begin
            failures++;
            $display("FAIL %s: press=%b release=%b repeat=%b expected all 0",
                     name, btn_press, btn_release, btn_repeat);
        end
    endtask

    task automatic observe(input int kind, input int ch);
        int idx;
        idx = -1;
        checks++;
        foreach (exp_q[i])
            if (idx < 0 && exp_q[i].kind == kind && exp_q[i].ch == ch) idx = i;
        if (idx < 0) begin
            failures++;
            $display("FAIL unexpected_%s ch%0d: pulse at cycle %0d, expected none", kname(kind), ch, cyc);
        end else begin
            if (exp_q[idx].at != cyc) begin
                failures++;
                $display("FAIL %s_timing ch%0d: pulse at cycle %0d, expected cycle %0d",
                         kname(kind), ch, cyc, exp_q[idx].at);
            end
            exp_q.delete(idx);
        end
    endtask

    // Monitor: every asserted pulse bit must match a queued expectation.
    always @(negedge clk) begin
        for (int ch = 0; ch < 2; ch++) begin
            if (btn_press[ch])   observe(0, ch);
            if (btn_release[ch]) observe(1, ch);
            if (btn_repeat[ch])  observe(2, ch);
        end
    end

    initial begin
        int e, p, f, g;
        rst_n = 1'b0;
        btn_n = 2'b11;
        step(3);
        check_level("reset_level", 2'b00);
        check_pulses_zero("reset_pulses");
        rst_n = 1'b1;
        step(50);
        check_level("idle_50", 2'b00);

        // Clean press on channel 0, hold with a short glitch, then release.
        e = cyc;
        btn_n[0] = 1'b0;
        p = e + 6;
        expect_ev(0, 0, p);
`ifdef BTN_AUTOREPEAT_EN
        for (int t = p + 20; t < p + 56; t += 8) expect_ev(2, 0, t);
`endif
        step(5);
        check_level("press_pre", 2'b00);
        step(1);
        check_level("press_edge6", 2'b01);
        step(10);
        btn_n[0] = 1'b1;
        step(2);
        btn_n[0] = 1'b0;
        step(10);
        check_level("hold_glitch", 2'b01);
        step(p + 50 - cyc);
        btn_n[0] = 1'b1;
        expect_ev(1, 0, p + 56);
        step(5);
        check_level("release_pre", 2'b01);
        step(1);
        check_level("release_edge6", 2'b00);
        step(20);

        // Bounce train: no run of low samples reaches the debounce count.
        btn_n[0] = 1'b0; step(3);
        btn_n[0] = 1'b1; step(1);
        btn_n[0] = 1'b0; step(3);
        btn_n[0] = 1'b1;
        step(10);
        check_level("bounce", 2'b00);

        // Both channels pressed, then async reset while held.
        f = cyc;
        btn_n = 2'b00;
        expect_ev(0, 0, f + 6);
        expect_ev(0, 1, f + 6);
        step(6);
        check_level("dual_press", 2'b11);
        step(4);
        #2 rst_n = 1'b0;
        #1 check_level("async_reset", 2'b00);
        check_pulses_zero("async_reset_pulses");
        step(2);
        rst_n = 1'b1;
        g = cyc;
        expect_ev(0, 0, g + 6);
        expect_ev(0, 1, g + 6);
        step(5);
        check_level("post_reset_pre", 2'b00);
        step(1);
        check_level("post_reset_press", 2'b11);
        step(4);
        btn_n = 2'b11;
        expect_ev(1, 0, g + 16);
        expect_ev(1, 1, g + 16);
        step(6);
        check_level("dual_release", 2'b00);
        step(20);

        foreach (exp_q[i]) begin
            checks++;
            failures++;
            $display("FAIL missing_%s ch%0d: no pulse seen, expected at cycle %0d",
                     kname(exp_q[i].kind), exp_q[i].ch, exp_q[i].at);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
